mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_scan_if.sv | 29 ++
 rtl/mux_scan_ctr.sv | 56 +++++
 rtl/mux_scan.sv | 90 +++++++++
 tb/tb_mux_scan.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared parameter defaults, mode encoding and index-width helper for the
// channel multiplexer/scanner.
package mux_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 8;
  localparam int DWELL_DEF = 4;

  typedef enum logic {
    MODE_MAN  = 1'b0,
    MODE_SCAN = 1'b1
  } mode_e;

  // Channel-index width; never below one bit so a 2-channel mux still has an index.
  function automatic int sw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Channel data, control and result bundle between a driver and mux_scan.
interface mux_scan_if
  import mux_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  localparam int SW = sw_of(N);

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           en;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           valid;
  logic           wrap;

  modport master (
    output din, sel, mode, en,
    input  y, ch, valid, wrap
  );

  modport slave (
    input  din, sel, mode, en,
    output y, ch, valid, wrap
  );

endinterface

// File: rtl/mux_scan_ctr.sv
// Scan index and dwell counter; loaded from sel outside scan mode and
// stepped once per enabled scan cycle.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DWELL = DWELL_DEF,
  parameter int SW    = sw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [SW-1:0] load_val,
  input  logic          adv_en,
  output logic [SW-1:0] cur,
  output logic          wrap_next
);

  logic [SW-1:0] cur_r;
  logic [7:0]    dcnt_r;
  logic          wrap_pend_r;
  logic          last_s;

  assign last_s    = (dcnt_r == 8'(DWELL - 1));
  assign cur       = cur_r;
  // Flags that the next scan sample is the first one on channel 0 after a wrap.
  assign wrap_next = wrap_pend_r;

  // Index, dwell count and pending-wrap flag update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_r       <= '0;
      dcnt_r      <= 8'd0;
      wrap_pend_r <= 1'b0;
    end else if (load) begin
      cur_r       <= load_val;
      dcnt_r      <= 8'd0;
      wrap_pend_r <= 1'b0;
    end else if (adv_en) begin
      if (last_s) begin
        cur_r       <= cur_r + SW'(1);
        dcnt_r      <= 8'd0;
        wrap_pend_r <= (cur_r == SW'(N - 1));
      end else begin
        cur_r       <= cur_r;
        dcnt_r      <= dcnt_r + 8'd1;
        wrap_pend_r <= 1'b0;
      end
    end else begin
      cur_r       <= cur_r;
      dcnt_r      <= dcnt_r;
      wrap_pend_r <= wrap_pend_r;
    end
  end

endmodule

// File: rtl/mux_scan.sv
// N:1 registered channel multiplexer with manual select and auto-scan modes;
// the scan sequencing lives in mux_scan_ctr.
module mux_scan
  import mux_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.slave  bus
);

  localparam int SW = sw_of(N);

  logic          scan_s;
  logic [SW-1:0] cur_s;
  logic          wrap_next_s;
  logic [SW-1:0] idx_s;
  logic [W-1:0]  sel_data_s;
  logic [W-1:0]  y_r;
  logic [SW-1:0] ch_r;
  logic          valid_r;
  logic          wrap_r;

  assign scan_s = (mode_e'(bus.mode) == MODE_SCAN);

  mux_scan_ctr #(
    .N     (N),
    .DWELL (DWELL),
    .SW    (SW)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (!scan_s),
    .load_val  (bus.sel),
    .adv_en    (scan_s && bus.en),
    .cur       (cur_s),
    .wrap_next (wrap_next_s)
  );

  // Channel index: sel in manual mode, the scan index otherwise.
  always_comb begin
    idx_s = bus.sel;
    if (scan_s) begin
      idx_s = cur_s;
    end else begin
      idx_s = bus.sel;
    end
  end

  // N:1 data select.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_s == SW'(k)) begin
        sel_data_s = bus.din[k*W +: W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output register; y and ch hold while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_r     <= '0;
      ch_r    <= '0;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else if (bus.en) begin
      y_r     <= sel_data_s;
      ch_r    <= idx_s;
      valid_r <= 1'b1;
      wrap_r  <= scan_s ? wrap_next_s : 1'b0;
    end else begin
      y_r     <= y_r;
      ch_r    <= ch_r;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end
  end

  assign bus.y     = y_r;
  assign bus.ch    = ch_r;
  assign bus.valid = valid_r;
  assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench: an 8-channel DWELL=2 instance and a
// 2-channel DWELL=1 instance sharing clock and reset.
module tb_mux_scan;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mux_scan_if #(.N(8), .W(8)) a ();
  mux_scan_if #(.N(2), .W(8)) b ();

  mux_scan #(.N(8), .W(8), .DWELL(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(a));
  mux_scan #(.N(2), .W(8), .DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and let outputs settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] ch_e, input logic v_e,
                       input logic w_e, input logic [7:0] y_e);
    chk({tag, ".ch"},    32'(a.ch),    32'(ch_e));
    chk({tag, ".valid"}, 32'(a.valid), 32'(v_e));
    chk({tag, ".wrap"},  32'(a.wrap),  32'(w_e));
    chk({tag, ".y"},     32'(a.y),     32'(y_e));
  endtask

  task automatic chk_b(input string tag, input logic ch_e, input logic w_e, input logic [7:0] y_e);
    chk({tag, ".ch"},    32'(b.ch),    32'(ch_e));
    chk({tag, ".valid"}, 32'(b.valid), 32'(1'b1));
    chk({tag, ".wrap"},  32'(b.wrap),  32'(w_e));
    chk({tag, ".y"},     32'(b.y),     32'(y_e));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int k = 0; k < 8; k++) a.din[k*8 +: 8] = 8'h10 + 8'(k);
    a.sel  = 3'd0;
    a.mode = 1'b0;
    a.en   = 1'b0;
    b.din  = {8'hB1, 8'hB0};
    b.sel  = 1'b1;
    b.mode = 1'b1;
    b.en   = 1'b0;
    rst_n  = 1'b0;

    // Reset state
    step();
    chk_a("rst", 3'd0, 1'b0, 1'b0, 8'h00);
    chk({"rst_b", ".y"}, 32'(b.y), 32'h0);
    rst_n = 1'b1;

    // Manual select of channel 5
    a.sel = 3'd5; a.en = 1'b1;
    step();
    chk_a("man5", 3'd5, 1'b1, 1'b0, 8'h15);

    // Scan from channel 6, en held
    a.sel = 3'd6;
    step();
    chk_a("man6", 3'd6, 1'b1, 1'b0, 8'h16);
    a.mode = 1'b1;
    step(); chk_a("scan_e1", 3'd6, 1'b1, 1'b0, 8'h16);
    a.sel = 3'd3;
    step(); chk_a("scan_e2", 3'd6, 1'b1, 1'b0, 8'h16);
    step(); chk_a("scan_e3", 3'd7, 1'b1, 1'b0, 8'h17);
    step(); chk_a("scan_e4", 3'd7, 1'b1, 1'b0, 8'h17);
    step(); chk_a("scan_e5", 3'd0, 1'b1, 1'b1, 8'h10);
    step(); chk_a("scan_e6", 3'd0, 1'b1, 1'b0, 8'h10);
    step(); chk_a("scan_e7", 3'd1, 1'b1, 1'b0, 8'h11);

    // Back to manual at channel 2, then scan with en toggling and sel changing
    a.mode = 1'b0; a.sel = 3'd2;
    step(); chk_a("man2", 3'd2, 1'b1, 1'b0, 8'h12);
    a.mode = 1'b1;
    step(); chk_a("tog1", 3'd2, 1'b1, 1'b0, 8'h12);
    a.en = 1'b0; a.sel = 3'd7;
    step(); chk_a("tog2", 3'd2, 1'b0, 1'b0, 8'h12);
    a.en = 1'b1; a.sel = 3'd0;
    step(); chk_a("tog3", 3'd2, 1'b1, 1'b0, 8'h12);
    a.en = 1'b0; a.sel = 3'd5;
    step(); chk_a("tog4", 3'd2, 1'b0, 1'b0, 8'h12);
    a.en = 1'b1;
    step(); chk_a("tog5", 3'd3, 1'b1, 1'b0, 8'h13);
    a.en = 1'b0;
    step(); chk_a("tog6", 3'd3, 1'b0, 1'b0, 8'h13);

    // Reset mid-dwell on channel 3, release straight into scan
    rst_n = 1'b0; a.en = 1'b1;
    step(); chk_a("rst_mid", 3'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step(); chk_a("rscan1", 3'd0, 1'b1, 1'b0, 8'h10);
    step(); chk_a("rscan2", 3'd0, 1'b1, 1'b0, 8'h10);
    step(); chk_a("rscan3", 3'd1, 1'b1, 1'b0, 8'h11);

    // Leave scan immediately; manual en=0 holds y
    a.mode = 1'b0; a.sel = 3'd2;
    step(); chk_a("leave", 3'd2, 1'b1, 1'b0, 8'h12);
    a.en = 1'b0; a.sel = 3'd7;
    step(); chk_a("man_hold", 3'd2, 1'b0, 1'b0, 8'h12);

    // Load of start channel with en=0, then scan across the top boundary
    a.mode = 1'b1; a.en = 1'b1;
    step(); chk_a("top1", 3'd7, 1'b1, 1'b0, 8'h17);
    step(); chk_a("top2", 3'd7, 1'b1, 1'b0, 8'h17);
    step(); chk_a("top3", 3'd0, 1'b1, 1'b1, 8'h10);
    a.en = 1'b0;

    // Two channels, DWELL=1
    b.en = 1'b1;
    step(); chk_b("n2_0", 1'b0, 1'b0, 8'hB0);
    step(); chk_b("n2_1", 1'b1, 1'b0, 8'hB1);
    step(); chk_b("n2_2", 1'b0, 1'b1, 8'hB0);
    step(); chk_b("n2_3", 1'b1, 1'b0, 8'hB1);
    step(); chk_b("n2_4", 1'b0, 1'b1, 8'hB0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
